stage_ex_muldiv: RTL and testbench

STAGE_EX_MULDIV -- requirements
Module: stage_ex_muldiv

---
 rtl/stage_ex_muldiv.sv | 226 ++++++++++++++++++++++
 tb/tb_stage_ex_muldiv.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_ex_muldiv.sv
// stage_ex_muldiv: execute stage for logic ops, HI/LO moves, multiply and
// multi-cycle restoring divide.
//
// Ports:
//   clock, reset            sole clock; asynchronous active-high reset
//   annul                   flush; cancels an in-progress divide and any HI/LO write
//   operator, category      operation code and result category (001 logic, 011 move)
//   operand_a, operand_b    source operands (operand_b is the divisor)
//   register_write_enable_, register_write_address_   write control from decode
//   register_write_enable, register_write_address     write control to memory stage
//   register_write_data     write-back value
//   stall_request           upstream must hold operator/operands
//   hi, lo                  current HI/LO contents
module stage_ex_muldiv #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             annul,
  input  logic [7:0]       operator,
  input  logic [2:0]       category,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             register_write_enable_,
  input  logic [4:0]       register_write_address_,
  output logic             register_write_enable,
  output logic [4:0]       register_write_address,
  output logic [WIDTH-1:0] register_write_data,
  output logic             stall_request,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [7:0] OpAnd   = 8'h24;
  localparam logic [7:0] OpOr    = 8'h25;
  localparam logic [7:0] OpXor   = 8'h26;
  localparam logic [7:0] OpNor   = 8'h27;
  localparam logic [7:0] OpMfhi  = 8'h10;
  localparam logic [7:0] OpMthi  = 8'h11;
  localparam logic [7:0] OpMflo  = 8'h12;
  localparam logic [7:0] OpMtlo  = 8'h13;
  localparam logic [7:0] OpMult  = 8'h18;
  localparam logic [7:0] OpMultu = 8'h19;
  localparam logic [7:0] OpDiv   = 8'h1A;
  localparam logic [7:0] OpDivu  = 8'h1B;

  localparam logic [2:0] CatLogic = 3'b001;
  localparam logic [2:0] CatMove  = 3'b011;

  localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]       quo_q, quo_d;   // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]       rem_q, rem_d;
  logic [WIDTH-1:0]       divisor_q, divisor_d;
  logic                   quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  logic [WIDTH-1:0]   logic_res, move_res;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic               is_signed_div, div_start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   quo_final, rem_final;

  assign register_write_enable  = register_write_enable_;
  assign register_write_address = register_write_address_;
  assign hi = hi_q;
  assign lo = lo_q;

  // Combinational results
  always_comb begin
    logic_res = '0;
    case (operator)
      OpAnd:   logic_res = operand_a & operand_b;
      OpOr:    logic_res = operand_a | operand_b;
      OpXor:   logic_res = operand_a ^ operand_b;
      OpNor:   logic_res = ~(operand_a | operand_b);
      default: logic_res = '0;
    endcase
    move_res = '0;
    case (operator)
      OpMfhi:  move_res = hi_q;
      OpMflo:  move_res = lo_q;
      default: move_res = '0;
    endcase
    register_write_data = '0;
    if (!reset) begin
      case (category)
        CatLogic: register_write_data = logic_res;
        CatMove:  register_write_data = move_res;
        default:  register_write_data = '0;
      endcase
    end
  end

  // Multiply: sign- or zero-extend to 2*WIDTH so the low 2*WIDTH product bits are exact.
  always_comb begin
    if (operator == OpMult) begin
      a_ext = {{WIDTH{operand_a[WIDTH-1]}}, operand_a};
      b_ext = {{WIDTH{operand_b[WIDTH-1]}}, operand_b};
    end else begin
      a_ext = {{WIDTH{1'b0}}, operand_a};
      b_ext = {{WIDTH{1'b0}}, operand_b};
    end
    product = a_ext * b_ext;
  end

  // Divide setup and one restoring step
  always_comb begin
    is_signed_div = (operator == OpDiv);
    div_start     = ((operator == OpDiv) || (operator == OpDivu)) && (operand_b != '0);
    mag_a = (is_signed_div && operand_a[WIDTH-1]) ? (~operand_a + WIDTH'(1)) : operand_a;
    mag_b = (is_signed_div && operand_b[WIDTH-1]) ? (~operand_b + WIDTH'(1)) : operand_b;
    // Top bit of trial set means the partial remainder was smaller than the divisor.
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};
    quo_final = quo_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
    rem_final = rem_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
  end

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (annul) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (div_start) state_d = StBusy;
        StBusy:  if (cnt_q == LastCount) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    stall_request = 1'b0;
    if (!reset && !annul) begin
      unique case (state_q)
        StIdle:  stall_request = div_start;
        StBusy:  stall_request = 1'b1;
        StDone:  stall_request = 1'b0;
        default: stall_request = 1'b0;
      endcase
    end
  end

  // Divider datapath and HI/LO next state
  always_comb begin
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    divisor_d = divisor_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (state_q == StIdle && div_start) begin
      quo_d     = mag_a;
      rem_d     = '0;
      divisor_d = mag_b;
      quo_neg_d = is_signed_div && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      rem_neg_d = is_signed_div && operand_a[WIDTH-1];
      cnt_d     = '0;
    end else if (state_q == StBusy) begin
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + COUNT_WIDTH'(1);
    end
    if (!annul) begin
      if (state_q == StDone) begin
        hi_d = rem_final;
        lo_d = quo_final;
      end else if (state_q == StIdle) begin
        case (operator)
          OpMthi:          hi_d = operand_a;
          OpMtlo:          lo_d = operand_a;
          OpMult, OpMultu: begin
            hi_d = product[2*WIDTH-1:WIDTH];
            lo_d = product[WIDTH-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      divisor_q <= divisor_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_stage_ex_muldiv.sv
module tb_stage_ex_muldiv;

  localparam logic [7:0] OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26, OP_NOR = 8'h27;
  localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clock = 1'b0;
  logic        reset, annul;
  logic [7:0]  operator;
  logic [2:0]  category;
  logic [31:0] operand_a, operand_b;
  logic        we_in, we_out;
  logic [4:0]  addr_in, addr_out;
  logic [31:0] data, hi, lo;
  logic        stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;  // reference HI/LO

  stage_ex_muldiv #(.WIDTH(32), .COUNT_WIDTH(6)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .annul                   (annul),
    .operator                (operator),
    .category                (category),
    .operand_a               (operand_a),
    .operand_b               (operand_b),
    .register_write_enable_  (we_in),
    .register_write_address_ (addr_in),
    .register_write_enable   (we_out),
    .register_write_address  (addr_out),
    .register_write_data     (data),
    .stall_request           (stall),
    .hi                      (hi),
    .lo                      (lo)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] cat,
                       input logic [31:0] a, input logic [31:0] b);
    operator  = op;
    category  = cat;
    operand_a = a;
    operand_b = b;
  endtask

  function automatic logic [31:0] ref_logic(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (op == OP_AND) return a & b;
    if (op == OP_OR)  return a | b;
    if (op == OP_XOR) return a ^ b;
    if (op == OP_NOR) return ~(a | b);
    return 32'h0;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    annul = 1'b0;
    we_in = 1'b1;
    addr_in = 5'h1A;
    drive(OP_DIVU, 3'b001, 32'h1234, 32'h5);
    #3;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: hi=%h lo=%h expected 0/0", hi, lo);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 0", stall);
    end
    drive(OP_OR, 3'b001, 32'hF0F0, 32'h0F0F);
    #1;
    checks++;
    if (data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", data);
    end
    checks++;
    if (we_out !== 1'b1 || addr_out !== 5'h1A) begin
      errors++;
      $display("FAIL reset_passthru: got %b/%h expected 1/1a", we_out, addr_out);
    end
    @(negedge clock);
    reset = 1'b0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    step();
  endtask

  task automatic test_logic();
    logic [7:0]  ops[4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
    logic [7:0]  op;
    logic [31:0] a, b;
    logic [2:0]  cat;
    drive(OP_OR, 3'b001, 32'h0000F0F0, 32'h00FF0000);
    #1;
    checks++;
    if (data !== 32'h00FFF0F0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL or_fixed: data=%h stall=%b expected 00fff0f0/0", data, stall);
    end
    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(0, 3)];
      a = $urandom;
      b = $urandom;
      we_in = 1'($urandom);
      addr_in = 5'($urandom);
      drive(op, 3'b001, a, b);
      #1;
      checks++;
      if (data !== ref_logic(op, a, b) || stall !== 1'b0) begin
        errors++;
        $display("FAIL logic_rand op=%h: data=%h stall=%b expected %h/0",
                 op, data, stall, ref_logic(op, a, b));
      end
      checks++;
      if (we_out !== we_in || addr_out !== addr_in) begin
        errors++;
        $display("FAIL passthru: got %b/%h expected %b/%h", we_out, addr_out, we_in, addr_in);
      end
      // Categories other than logic/move yield zero.
      cat = 3'($urandom_range(0, 7));
      if (cat == 3'b001 || cat == 3'b011) cat = 3'b110;
      category = cat;
      #1;
      checks++;
      if (data !== 32'h0) begin
        errors++;
        $display("FAIL other_category cat=%b: data=%h expected 0", cat, data);
      end
    end
    drive(8'h3F, 3'b001, 32'hFFFF_FFFF, 32'h1234_5678);
    #1;
    checks++;
    if (data !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL unknown_op: data=%h stall=%b expected 0/0", data, stall);
    end
    step();
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL unknown_op_hilo: hi=%h lo=%h expected %h/%h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_move_mult();
    logic [31:0] a, b;
    logic [63:0] p;
    logic        sgn;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      drive((i % 2 == 0) ? OP_MTHI : OP_MTLO, 3'b011, a, $urandom);
      step();
      if (i % 2 == 0) m_hi = a;
      else            m_lo = a;
      drive((i % 2 == 0) ? OP_MFHI : OP_MFLO, 3'b011, $urandom, $urandom);
      #1;
      checks++;
      if (data !== ((i % 2 == 0) ? m_hi : m_lo) || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL move %0d: data=%h hi=%h lo=%h expected hi=%h lo=%h",
                 i, data, hi, lo, m_hi, m_lo);
      end
    end
    drive(OP_MULT, 3'b000, 32'hFFFFFFFE, 32'h3);
    step();
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_fixed: hi=%h lo=%h expected ffffffff/fffffffa", hi, lo);
    end
    m_hi = 32'hFFFFFFFF;
    m_lo = 32'hFFFFFFFA;
    drive(OP_MFHI, 3'b011, 32'h0, 32'h0);
    #1;
    checks++;
    if (data !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL mfhi_after_mult: data=%h expected ffffffff", data);
    end
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      sgn = 1'($urandom);
      if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else     p = {32'h0, a} * {32'h0, b};
      drive(sgn ? OP_MULT : OP_MULTU, 3'b001, a, b);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL mult_stall: got %b expected 0", stall);
      end
      step();
      m_hi = p[63:32];
      m_lo = p[31:0];
      checks++;
      if (hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL mult_rand signed=%b a=%h b=%h: hi=%h lo=%h expected %h/%h",
                 sgn, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  // Issues one divide and follows it to completion, checking stall length and results.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [31:0] exp_hi, exp_lo;
    int          cnt;
    if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    if (b != 32'h0) begin
      q = sa / sb;
      r = sa % sb;
      exp_lo = q[31:0];
      exp_hi = r[31:0];
    end else begin
      exp_lo = m_lo;
      exp_hi = m_hi;
    end
    drive(op, 3'b000, a, b);
    cnt = 0;
    #1;
    while (stall === 1'b1 && cnt < 200) begin
      cnt++;
      step();
    end
    checks++;
    if (cnt != ((b != 32'h0) ? 33 : 0)) begin
      errors++;
      $display("FAIL div_stall_len op=%h a=%h b=%h: got %0d cycles expected %0d",
               op, a, b, cnt, (b != 32'h0) ? 33 : 0);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL div_early_write: hi=%h lo=%h expected %h/%h", hi, lo, m_hi, m_lo);
    end
    step();
    m_hi = exp_hi;
    m_lo = exp_lo;
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL div_result op=%h a=%h b=%h: hi=%h lo=%h expected %h/%h",
               op, a, b, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    do_div(OP_DIV, 32'hFFFFFFF9, 32'h2);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_fixed: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
    end
    do_div(OP_DIVU, 32'h7, 32'h2);
    checks++;
    if (lo !== 32'h3 || hi !== 32'h1) begin
      errors++;
      $display("FAIL divu_fixed: hi=%h lo=%h expected 1/3", hi, lo);
    end
    do_div(OP_DIV, 32'h7, 32'hFFFFFFFE);
    do_div(OP_DIVU, 32'hFFFFFFFF, 32'h1);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (b == 32'h0) b = 32'h1;
      do_div((i % 2 == 0) ? OP_DIV : OP_DIVU, a, b);
    end
  endtask

  task automatic test_div_zero();
    drive(OP_MTHI, 3'b000, 32'h11, 32'h0);
    step();
    drive(OP_MTLO, 3'b000, 32'h22, 32'h0);
    step();
    m_hi = 32'h11;
    m_lo = 32'h22;
    drive(OP_DIVU, 3'b000, 32'h55, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL divzero_stall cycle %0d: got %b expected 0", i, stall);
      end
      step();
    end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++;
      $display("FAIL divzero_hilo: hi=%h lo=%h expected 11/22", hi, lo);
    end
    do_div(OP_DIV, 32'h80000000, 32'h0);
  endtask

  task automatic test_annul();
    drive(OP_DIVU, 3'b000, 32'd1000, 32'd3);
    repeat (11) step();
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL annul_pre_busy: stall=%b expected 1", stall);
    end
    annul = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL annul_cycle_stall: stall=%b expected 0", stall);
    end
    step();
    annul = 1'b0;
    drive(OP_NOP, 3'b000, 32'h0, 32'h0);
    #1;
    checks++;
    if (stall !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL annul_after: stall=%b hi=%h lo=%h expected 0/%h/%h",
               stall, hi, lo, m_hi, m_lo);
    end
    repeat (40) step();
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL annul_late_write: hi=%h lo=%h expected %h/%h", hi, lo, m_hi, m_lo);
    end
    // Annul also blocks direct HI/LO writes.
    drive(OP_MULT, 3'b000, 32'h1234, 32'h5678);
    annul = 1'b1;
    step();
    annul = 1'b0;
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL annul_mult: hi=%h lo=%h expected %h/%h", hi, lo, m_hi, m_lo);
    end
    do_div(OP_DIVU, 32'd100, 32'd7);
    checks++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      errors++;
      $display("FAIL annul_then_divu: hi=%h lo=%h expected 2/e", hi, lo);
    end
  endtask

  task automatic test_reset_mid_div();
    drive(OP_MTHI, 3'b000, 32'hDEAD, 32'h0);
    step();
    drive(OP_MTLO, 3'b000, 32'hBEEF, 32'h0);
    step();
    drive(OP_DIV, 3'b000, 32'h12345, 32'h77);
    repeat (6) step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_div: hi=%h lo=%h stall=%b expected 0/0/0", hi, lo, stall);
    end
    m_hi = 32'h0;
    m_lo = 32'h0;
    drive(OP_NOP, 3'b000, 32'h0, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) step();
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: hi=%h lo=%h stall=%b expected 0/0/0", hi, lo, stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom_range(1, 1000);
      do_div((i % 2 == 0) ? OP_DIVU : OP_DIV, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_logic();
    test_move_mult();
    test_div();
    test_div_zero();
    test_annul();
    test_reset_mid_div();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
